// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the decode stage (master) and imm_gen_pipe (slave).
// Signal names match the original flat port list.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [2:0]        ImmSrc;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   ImmExt;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  logic [15:0]       imm_count;

  modport master (
    output in_valid, instr, ImmSrc, in_tag, out_ready,
    input  in_ready, out_valid, ImmExt, out_tag, out_err, imm_count
  );

  modport slave (
    input  in_valid, instr, ImmSrc, in_tag, out_ready,
    output in_ready, out_valid, ImmExt, out_tag, out_err, imm_count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the immediate on accept and queues
// {imm, tag, err} in a 2-entry FIFO; outputs always show the head entry.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  imm_gen_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    FMT_I   = 3'b000,
    FMT_S   = 3'b001,
    FMT_U   = 3'b010,
    FMT_Z   = 3'b011,
    FMT_SH  = 3'b100,
    FMT_B   = 3'b101,
    FMT_J   = 3'b110,
    FMT_ERR = 3'b111
  } fmt_e;

  logic [XLEN-1:0]  w_imm;
  logic             w_err;
  logic             w_push;
  logic             w_pop;
  logic             w_out_valid;
  logic             w_in_ready;

  logic [XLEN-1:0]  r_imm [2];
  logic [TAG_W-1:0] r_tag [2];
  logic             r_err [2];
  logic [1:0]       r_count;
  logic             r_rd;
  logic             r_wr;
  logic [15:0]      r_hs_cnt;

  always_comb begin
    w_imm = '0;
    w_err = 1'b0;
    case (fmt_e'(bus.ImmSrc))
      FMT_I:   w_imm = XLEN'($signed(bus.instr[31:20]));
      FMT_S:   w_imm = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
      FMT_B:   w_imm = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25],
                                      bus.instr[11:8], 1'b0}));
      FMT_U:   w_imm = XLEN'($signed({bus.instr[31:12], 12'h000}));
      FMT_J:   w_imm = XLEN'($signed({bus.instr[31], bus.instr[19:12], bus.instr[20],
                                      bus.instr[30:21], 1'b0}));
      FMT_Z:   w_imm = XLEN'(bus.instr[19:15]);
      // RV64 shifts use a 6-bit shamt, RV32 only 5 bits
      FMT_SH:  w_imm = (XLEN == 64) ? XLEN'(bus.instr[25:20]) : XLEN'(bus.instr[24:20]);
      default: w_err = 1'b1;
    endcase
  end

  // in_ready depends only on the registered count, never on out_ready
  assign w_in_ready  = (r_count != 2'd2);
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_hs_cnt <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_imm[i] <= '0;
        r_tag[i] <= '0;
        r_err[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_imm[r_wr] <= w_imm;
        r_tag[r_wr] <= bus.in_tag;
        r_err[r_wr] <= w_err;
        r_wr        <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
        if (r_hs_cnt != '1)
          r_hs_cnt <= r_hs_cnt + 16'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.ImmExt    = w_out_valid ? r_imm[r_rd] : '0;
  assign bus.out_tag   = w_out_valid ? r_tag[r_rd] : '0;
  assign bus.out_err   = w_out_valid ? r_err[r_rd] : 1'b0;
  assign bus.imm_count = r_hs_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe at XLEN=32 and XLEN=64.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(4)) bus32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(4)) bus64 ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(4)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(4)) u_dut64 (.clk(clk), .rst(rst), .bus(bus64));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [2:0] src, input logic [31:0] ins,
                         input logic [3:0] tg);
    bus32.in_valid = v;
    bus32.ImmSrc   = src;
    bus32.instr    = ins;
    bus32.in_tag   = tg;
  endtask

  task automatic drive64(input logic v, input logic [2:0] src, input logic [31:0] ins,
                         input logic [3:0] tg);
    bus64.in_valid = v;
    bus64.ImmSrc   = src;
    bus64.instr    = ins;
    bus64.in_tag   = tg;
  endtask

  typedef struct {
    logic [2:0]  src;
    logic [31:0] ins;
    logic [63:0] exp;
  } vec_t;

  vec_t v32 [7];
  vec_t v64 [5];

  initial begin
    v32[0] = '{3'b101, 32'hFE000EE3, 64'hFFFFFFFC};
    v32[1] = '{3'b110, 32'h0010006F, 64'h00000800};
    v32[2] = '{3'b011, 32'h000F8073, 64'h0000001F};
    v32[3] = '{3'b001, 32'h00A12423, 64'h00000008};
    v32[4] = '{3'b010, 32'h800000B7, 64'h80000000};
    v32[5] = '{3'b100, 32'h03F00013, 64'h0000001F};
    v32[6] = '{3'b000, 32'h7FF00093, 64'h000007FF};

    v64[0] = '{3'b010, 32'h800000B7, 64'hFFFFFFFF80000000};
    v64[1] = '{3'b100, 32'h03F00013, 64'h000000000000003F};
    v64[2] = '{3'b101, 32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC};
    v64[3] = '{3'b110, 32'h8000006F, 64'hFFFFFFFFFFF00000};
    v64[4] = '{3'b111, 32'hFFFFFFFF, 64'h0000000000000000};

    drive32(1'b0, 3'b000, 32'h0, 4'h0);
    drive64(1'b0, 3'b000, 32'h0, 4'h0);
    bus32.out_ready = 1'b1;
    bus64.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check("rst_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus32.in_ready),  64'd1);
    check("rst_immext",    64'(bus32.ImmExt),    64'd0);
    check("rst_tag_err",   64'({bus32.out_tag, bus32.out_err}), 64'd0);
    check("rst_count",     64'(bus32.imm_count), 64'd0);

    // single I-type, one-cycle latency
    drive32(1'b1, 3'b000, 32'hFFF00093, 4'd3);
    tick();
    check("i_valid", 64'(bus32.out_valid), 64'd1);
    check("i_imm",   64'(bus32.ImmExt),    64'hFFFFFFFF);
    check("i_tag",   64'(bus32.out_tag),   64'd3);
    check("i_err",   64'(bus32.out_err),   64'd0);
    drive32(1'b0, 3'b000, 32'h0, 4'h0);
    tick();
    check("i_count", 64'(bus32.imm_count), 64'd1);
    check("i_drain", 64'(bus32.out_valid), 64'd0);

    // mixed formats, one per cycle
    for (int i = 0; i < 7; i++) begin
      drive32(1'b1, v32[i].src, v32[i].ins, 4'(i));
      tick();
      check($sformatf("mix%0d_valid", i), 64'(bus32.out_valid), 64'd1);
      check($sformatf("mix%0d_imm", i),   64'(bus32.ImmExt),    v32[i].exp);
      check($sformatf("mix%0d_tag", i),   64'(bus32.out_tag),   64'(i));
    end
    drive32(1'b0, 3'b000, 32'h0, 4'h0);
    tick();
    check("mix_count", 64'(bus32.imm_count), 64'd8);
    check("empty_imm", 64'(bus32.ImmExt),    64'd0);

    // XLEN=64 stream
    for (int i = 0; i < 5; i++) begin
      drive64(1'b1, v64[i].src, v64[i].ins, 4'(i + 8));
      tick();
      check($sformatf("x64_%0d_imm", i), 64'(bus64.ImmExt),  v64[i].exp);
      check($sformatf("x64_%0d_tag", i), 64'(bus64.out_tag), 64'(i + 8));
      check($sformatf("x64_%0d_err", i), 64'(bus64.out_err), (i == 4) ? 64'd1 : 64'd0);
    end
    drive64(1'b0, 3'b000, 32'h0, 4'h0);
    tick();
    check("x64_count", 64'(bus64.imm_count), 64'd5);

    // unsupported format
    drive32(1'b1, 3'b111, 32'hFFFFFFFF, 4'd5);
    tick();
    check("err_imm",  64'(bus32.ImmExt),  64'd0);
    check("err_flag", 64'(bus32.out_err), 64'd1);
    check("err_tag",  64'(bus32.out_tag), 64'd5);
    drive32(1'b0, 3'b000, 32'h0, 4'h0);
    tick();
    check("err_count", 64'(bus32.imm_count), 64'd9);

    // backpressure: tags 1,2,3 with out_ready low
    bus32.out_ready = 1'b0;
    drive32(1'b1, 3'b000, 32'h00100093, 4'd1);
    tick();
    check("bp1_ready", 64'(bus32.in_ready), 64'd1);
    check("bp1_tag",   64'(bus32.out_tag),  64'd1);
    drive32(1'b1, 3'b000, 32'h00200093, 4'd2);
    tick();
    check("bp2_ready", 64'(bus32.in_ready), 64'd0);
    check("bp2_tag",   64'(bus32.out_tag),  64'd1);
    drive32(1'b1, 3'b000, 32'h00300093, 4'd3);
    tick();
    tick();
    check("bp3_ready", 64'(bus32.in_ready), 64'd0);
    check("bp3_tag",   64'(bus32.out_tag),  64'd1);
    check("bp3_imm",   64'(bus32.ImmExt),   64'd1);
    bus32.out_ready = 1'b1;
    tick();
    check("bp4_tag",   64'(bus32.out_tag),  64'd2);
    check("bp4_imm",   64'(bus32.ImmExt),   64'd2);
    check("bp4_ready", 64'(bus32.in_ready), 64'd1);
    tick();
    check("bp5_tag",   64'(bus32.out_tag),  64'd3);
    check("bp5_imm",   64'(bus32.ImmExt),   64'd3);
    drive32(1'b0, 3'b000, 32'h0, 4'h0);
    tick();
    check("bp_drain", 64'(bus32.out_valid), 64'd0);
    check("bp_count", 64'(bus32.imm_count), 64'd12);

    // reset with the buffer full
    bus32.out_ready = 1'b0;
    drive32(1'b1, 3'b000, 32'h00600093, 4'd6);
    tick();
    drive32(1'b1, 3'b000, 32'h00700093, 4'd7);
    tick();
    check("full_ready", 64'(bus32.in_ready), 64'd0);
    drive32(1'b0, 3'b000, 32'h0, 4'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_valid", 64'(bus32.out_valid), 64'd0);
    check("mrst_ready", 64'(bus32.in_ready),  64'd1);
    check("mrst_count", 64'(bus32.imm_count), 64'd0);
    check("mrst_imm",   64'(bus32.ImmExt),    64'd0);
    bus32.out_ready = 1'b1;
    drive32(1'b1, 3'b000, 32'h80000093, 4'd4);
    tick();
    check("post_imm", 64'(bus32.ImmExt),  64'hFFFFF800);
    check("post_tag", 64'(bus32.out_tag), 64'd4);
    drive32(1'b0, 3'b000, 32'h0, 4'h0);
    tick();
    check("post_count", 64'(bus32.imm_count), 64'd1);

    // imm_count saturation
    drive32(1'b1, 3'b000, 32'h00100093, 4'd9);
    repeat (65540) tick();
    drive32(1'b0, 3'b000, 32'h0, 4'h0);
    tick();
    check("sat_count", 64'(bus32.imm_count), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
